pwm_demod: RTL and testbench



---
 rtl/pwm_demod.sv | 104 ++++++++++
 tb/tb_pwm_demod.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_demod.sv
// PWM receiver: measures high-time between rising edges of a synchronised PWM line
// and converts it back to the signed sample, one strobe per carrier period.
module pwm_demod #(
  parameter int DATA_W      = 8,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 512
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pwm,
  output logic [DATA_W-1:0] data,
  output logic              valid,
  output logic              period_err,
  output logic              stuck
);

  localparam int PER   = 2 ** DATA_W;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int HI_W  = DATA_W + 1;

  localparam logic [CNT_W-1:0]         PER_C  = CNT_W'(PER);
  localparam logic [CNT_W-1:0]         TMO_C  = CNT_W'(TIMEOUT);
  localparam logic [DATA_W-1:0]        MAX_P  = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0]        MIN_N  = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic signed [DATA_W+1:0] OFFSET = (DATA_W+2)'(PER / 2);
  localparam logic signed [DATA_W+1:0] HI_LIM = (DATA_W+2)'(PER / 2 - 1);
  localparam logic signed [DATA_W+1:0] LO_LIM = -OFFSET;

  typedef enum logic {ACQ, MEAS} state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   pwm_s;
  logic                   pwm_d;
  logic                   rise;
  logic [CNT_W-1:0]       per_cnt;
  logic [HI_W-1:0]        hi_cnt;
  logic signed [DATA_W+1:0] diff;
  logic [DATA_W-1:0]      clamped;

  // NOTE: all state is updated with non-blocking assignments so every flop samples
  // the pre-edge values of its neighbours, which is what the shift chain relies on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      pwm_d  <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pwm};
      pwm_d  <= pwm_s;
    end
  end

  assign pwm_s = sync_q[SYNC_STAGES-1];
  assign rise  = pwm_s & ~pwm_d;

  // High-time recentred around zero, then clamped to the signed output range.
  assign diff = $signed({1'b0, hi_cnt}) - OFFSET;

  // NOTE: every branch assigns clamped, so no latch is inferred.
  always_comb begin
    if (diff > HI_LIM)      clamped = MAX_P;
    else if (diff < LO_LIM) clamped = MIN_N;
    else                    clamped = diff[DATA_W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ACQ;
      per_cnt    <= '0;
      hi_cnt     <= '0;
      data       <= '0;
      valid      <= 1'b0;
      period_err <= 1'b0;
      stuck      <= 1'b0;
    end else begin
      valid <= 1'b0;
      if (rise) begin
        // A rise always wins over a coincident timeout; in ACQ it only opens a frame.
        if (state == MEAS) begin
          data       <= clamped;
          period_err <= (per_cnt != PER_C);
          stuck      <= 1'b0;
          valid      <= 1'b1;
        end
        state   <= MEAS;
        per_cnt <= CNT_W'(1);
        hi_cnt  <= HI_W'(1);
      end else if (per_cnt == TMO_C) begin
        data       <= pwm_s ? MAX_P : MIN_N;
        stuck      <= 1'b1;
        period_err <= 1'b1;
        valid      <= 1'b1;
        state      <= ACQ;
        // The timeout cycle opens the next window so a flat line repeats every TIMEOUT cycles.
        per_cnt    <= CNT_W'(1);
      end else begin
        per_cnt <= per_cnt + 1'b1;
        if (state == MEAS && pwm_s && hi_cnt != '1)
          hi_cnt <= hi_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_demod.sv
// Self-checking bench for pwm_demod: directed and random PWM frames compared against
// a frame-level model built from the rise positions of the driven waveform.
module tb_pwm_demod;

  localparam int PER  = 256;
  localparam int HALF = 128;
  localparam int TMO  = 512;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       pwm = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       period_err;
  logic       stuck;

  pwm_demod #(.DATA_W(8), .SYNC_STAGES(2), .TIMEOUT(TMO)) dut (
    .clk(clk),
    .rst(rst),
    .pwm(pwm),
    .data(data),
    .valid(valid),
    .period_err(period_err),
    .stuck(stuck)
  );

  always #5 clk = ~clk;

  typedef struct { int idx; int data; bit err; bit stk; } ev_t;
  typedef struct { int cyc; logic [7:0] data; logic err; logic stk; } obs_t;

  bit   wave[$];
  ev_t  mq[$];
  obs_t obs[$];
  int   done  = 0;
  int   cyc   = 0;
  int   tests = 0;
  int   fails = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk)
    if (valid === 1'b1) obs.push_back('{cyc, data, period_err, stuck});

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int clamp_s(input int v);
    if (v > HALF - 1) return HALF - 1;
    if (v < -HALF)    return -HALF;
    return v;
  endfunction

  // Expected strobes: a rise closes the open frame; TMO cycles with no rise since the
  // last rise/timeout/reset give a stuck strobe and drop the frame reference.
  function automatic void build_model();
    int  rises[$];
    int  anchor = 0;
    int  fs     = 0;
    int  n      = wave.size();
    int  r;
    int  hi;
    bit  acq    = 1'b1;
    ev_t e;
    mq.delete();
    for (int i = 0; i < n; i++)
      if (wave[i] && (i == 0 || !wave[i-1])) rises.push_back(i);
    rises.push_back(n + TMO * 4);
    foreach (rises[k]) begin
      r = rises[k];
      while (anchor + TMO < r && anchor + TMO < n) begin
        e.idx  = anchor + TMO;
        e.data = wave[anchor + TMO] ? HALF - 1 : -HALF;
        e.err  = 1'b1;
        e.stk  = 1'b1;
        mq.push_back(e);
        acq    = 1'b1;
        anchor = anchor + TMO;
      end
      if (r < n) begin
        if (!acq) begin
          hi = 0;
          for (int j = fs; j < r; j++) hi += int'(wave[j]);
          e.idx  = r;
          e.data = clamp_s(hi - HALF);
          e.err  = ((r - fs) != PER);
          e.stk  = 1'b0;
          mq.push_back(e);
        end
        acq    = 1'b0;
        fs     = r;
        anchor = r;
      end
    end
  endfunction

  task automatic drive(input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      pwm = b;
      wave.push_back(b);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic frame(input int per, input int hi);
    drive(1'b1, hi);
    drive(1'b0, per - hi);
  endtask

  // Compares every model strobe old enough to have left the DUT pipeline.
  task automatic check_events(input string tag);
    int         lim;
    logic [7:0] ed;
    build_model();
    lim = wave.size() - 4;
    while (done < mq.size() && mq[done].idx <= lim) begin
      check({tag, "/present"}, 32'(obs.size() > done), 32'd1);
      if (obs.size() <= done) break;
      ed = mq[done].data[7:0];
      check({tag, "/data"}, {24'b0, obs[done].data}, {24'b0, ed});
      check({tag, "/period_err"}, {31'b0, obs[done].err}, {31'b0, mq[done].err});
      check({tag, "/stuck"}, {31'b0, obs[done].stk}, {31'b0, mq[done].stk});
      if (done > 0)
        check({tag, "/spacing"}, obs[done].cyc - obs[done-1].cyc, mq[done].idx - mq[done-1].idx);
      done++;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "/data"}, {24'b0, data}, 32'd0);
    check({tag, "/valid"}, {31'b0, valid}, 32'd0);
    check({tag, "/period_err"}, {31'b0, period_err}, 32'd0);
    check({tag, "/stuck"}, {31'b0, stuck}, 32'd0);
  endtask

  task automatic new_epoch();
    wave.delete();
    obs.delete();
    done = 0;
  endtask

  initial begin
    int per;
    int hi;

    #1 rst = 1'b1;
    #2 check_outputs_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    new_epoch();

    drive(1'b0, 10);
    repeat (4) frame(256, 192);
    check_events("high192");

    frame(256, 128);
    frame(256, 128);
    frame(256, 1);
    frame(256, 255);
    frame(256, 100);
    check_events("extremes");

    frame(250, 125);
    frame(256, 128);
    check_events("off_freq");

    frame(512, 100);
    frame(256, 128);
    check_events("corner_512");

    frame(5, 1);
    frame(256, 64);
    check_events("glitch");

    for (int i = 0; i < 16; i++) begin
      per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(200, 300)) : PER;
      hi  = int'($urandom_range(1, per - 1));
      frame(per, hi);
    end
    frame(256, 128);
    check_events("random");

    // Stuck high after a normal frame, then recovery.
    frame(256, 200);
    drive(1'b1, 1100);
    drive(1'b0, 40);
    frame(256, 64);
    frame(256, 64);
    frame(256, 64);
    check_events("stuck_high");

    drive(1'b0, 600);
    check_events("stuck_low");

    // Rise from ACQ, 100 high cycles into the new frame, then asynchronous reset.
    drive(1'b1, 100);
    #2 rst = 1'b1;
    pwm = 1'b0;
    #1 check_outputs_zero("async_reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    new_epoch();

    drive(1'b0, 10);
    frame(256, 192);
    check("first_rise_no_valid", obs.size(), 32'd0);
    frame(256, 192);
    frame(256, 128);
    check_events("post_reset");

    drive(1'b0, 8);
    check_events("final");
    check("no_extra_strobes", obs.size(), done);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
